vga_display_write_arb: RTL and testbench

Arbiter and clear sequencer in front of the VGA text display's character-buffer write port. It shares the single `wen / w_addr / w_data` port of the display among `N_REQ` requesters, such as the pipeline debugger's field writer and a CPU-mapped text console, using round-robin valid/ready arbitration. On request, it also takes over the port and fills the whole buffer with a clear character. It sits between the requesters and the display, in the 100 MHz display-write clock domain.

---
 rtl/pcpu.sv | 14 +
 rtl/vga_display_write_arb_if.sv | 29 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/vga_display_write_arb.sv | 101 ++++++++++
 tb/tb_vga_display_write_arb.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pcpu.sv
// Shared display-side constants and types used by the VGA write path.
package pcpu;
  localparam int VGA_DISP_ADDR_W = 12;
  localparam int VGA_DISP_DATA_W = 8;
  localparam logic [VGA_DISP_DATA_W-1:0] VGA_CLEAR_CHAR = 8'h20;
  localparam logic [VGA_DISP_ADDR_W-1:0] VGA_CLEAR_LAST = 12'd4095;

  typedef enum logic {VWA_IDLE, VWA_CLEAR} vga_wr_arb_state_t;

  // Position of the ofs-th candidate when scanning round-robin from base.
  function automatic int rr_wrap(input int base, input int ofs, input int n);
    return (base + ofs) % n;
  endfunction
endpackage

// File: rtl/vga_display_write_arb_if.sv
// Requester-side and display-side signals of the character-buffer write arbiter.
interface vga_display_write_arb_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();
  // Handshake: a requester raises req_valid[i] with stable req_addr/req_data
  // slices and holds them until req_ready[i]; a transfer happens in any cycle
  // where req_valid[i] & req_ready[i]. req_valid never depends on req_ready.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    clear_start;
  logic                    busy;
  logic                    display_wen;
  logic [ADDR_W-1:0]       display_w_addr;
  logic [DATA_W-1:0]       display_w_data;

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, busy, display_wen, display_w_addr, display_w_data
  );

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, busy, display_wen, display_w_addr, display_w_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module rr_arbiter
  import pcpu::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (i == rr_wrap(int'(ptr), k, N))) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = PTR_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/vga_display_write_arb.sv
// Round-robin arbiter and full-buffer clear sequencer in front of the
// display character-buffer write port.
module vga_display_write_arb
  import pcpu::*;
#(
  parameter int                 N_REQ      = 2,
  parameter int                 ADDR_W     = VGA_DISP_ADDR_W,
  parameter int                 DATA_W     = VGA_DISP_DATA_W,
  parameter logic [DATA_W-1:0]  CLEAR_CHAR = VGA_CLEAR_CHAR,
  parameter logic [ADDR_W-1:0]  CLEAR_LAST = VGA_CLEAR_LAST
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_display_write_arb_if.slave   bus,
  output vga_wr_arb_state_t        state_dbg
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  vga_wr_arb_state_t state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  gidx;
  logic              gany;
  logic              grant_ok;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Grants only exist in IDLE, never in the cycle a clear is requested.
  assign grant_ok      = (state_q == VWA_IDLE) && !bus.clear_start && !rst;
  assign bus.req_ready = grant_ok ? grant : '0;
  assign bus.busy      = (state_q == VWA_CLEAR);
  assign bus.display_wen    = wen_q;
  assign bus.display_w_addr = addr_q;
  assign bus.display_w_data = data_q;
  assign state_dbg          = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VWA_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VWA_IDLE:  if (bus.clear_start) state_d = VWA_CLEAR;
      VWA_CLEAR: if (cnt_q == CLEAR_LAST) state_d = VWA_IDLE;
      default:   state_d = VWA_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      VWA_IDLE: begin
        if (bus.clear_start) begin
          cnt_d = '0;
        end else if (gany) begin
          wen_d  = 1'b1;
          addr_d = bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
          data_d = bus.req_data[int'(gidx)*DATA_W +: DATA_W];
          ptr_d  = (int'(gidx) == N_REQ-1) ? '0 : gidx + PTR_W'(1);
        end
      end
      VWA_CLEAR: begin
        wen_d  = 1'b1;
        addr_d = cnt_q;
        data_d = CLEAR_CHAR;
        cnt_d  = (cnt_q == CLEAR_LAST) ? '0 : cnt_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_vga_display_write_arb.sv
// Directed bench for the display write arbiter: vector table plus clear/reset sequences.
module tb_vga_display_write_arb;
  import pcpu::*;

  localparam logic [11:0] CL_LAST = 12'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_wr_arb_state_t state_dbg;

  int tests = 0;
  int fails = 0;

  vga_display_write_arb_if #(.N_REQ(2), .ADDR_W(12), .DATA_W(8)) bus ();

  vga_display_write_arb #(
    .N_REQ(2), .ADDR_W(12), .DATA_W(8),
    .CLEAR_CHAR(8'h20), .CLEAR_LAST(CL_LAST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [11:0] a0;
    logic [7:0]  d0;
    logic [11:0] a1;
    logic [7:0]  d1;
    logic [1:0]  exp_ready;
    logic        exp_wen;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [11:0] a0, input logic [7:0] d0,
                       input logic [11:0] a1, input logic [7:0] d1, input logic cs);
    bus.req_valid   = v;
    bus.req_addr    = {a1, a0};
    bus.req_data    = {d1, d0};
    bus.clear_start = cs;
  endtask

  task automatic chk_out(input string nm, input logic [1:0] rdy, input logic wen,
                         input logic [11:0] addr, input logic [7:0] data, input logic busy);
    chk({nm, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({nm, ".wen"},   32'(bus.display_wen), 32'(wen));
    chk({nm, ".addr"},  32'(bus.display_w_addr), 32'(addr));
    chk({nm, ".data"},  32'(bus.display_w_data), 32'(data));
    chk({nm, ".busy"},  32'(bus.busy), 32'(busy));
  endtask

  // Clear with req0 waiting; optional second pulse while the counter is at 7.
  task automatic run_clear(input string nm, input bit mid_pulse);
    drive(2'b01, 12'h123, 8'h77, 12'h000, 8'h00, 1'b1);
    #1;
    chk({nm, ".start_ready"}, 32'(bus.req_ready), 32'd0);
    chk({nm, ".start_busy"},  32'(bus.busy), 32'd0);
    tick();
    for (int c = 1; c <= 17; c++) begin
      bus.clear_start = mid_pulse && (c == 8);
      #1;
      chk($sformatf("%s.c%0d.busy", nm, c), 32'(bus.busy), 32'(c <= 16));
      chk($sformatf("%s.c%0d.state", nm, c), 32'(state_dbg),
          32'((c <= 16) ? VWA_CLEAR : VWA_IDLE));
      chk($sformatf("%s.c%0d.wen", nm, c), 32'(bus.display_wen), 32'(c >= 2));
      if (c >= 2) begin
        chk($sformatf("%s.c%0d.addr", nm, c), 32'(bus.display_w_addr), 32'(c - 2));
        chk($sformatf("%s.c%0d.data", nm, c), 32'(bus.display_w_data), 32'h20);
      end
      chk($sformatf("%s.c%0d.ready", nm, c), 32'(bus.req_ready), (c == 17) ? 32'd1 : 32'd0);
      tick();
    end
    drive(2'b00, 12'h000, 8'h00, 12'h000, 8'h00, 1'b0);
    #1;
    chk_out({nm, ".after"}, 2'b00, 1'b1, 12'h123, 8'h77, 1'b0);
    tick();
  endtask

  initial begin
    tbl[0]  = '{2'b11, 12'h010, 8'h41, 12'h020, 8'h42, 2'b01, 1'b0, 12'h000, 8'h00};
    tbl[1]  = '{2'b11, 12'h010, 8'h41, 12'h020, 8'h42, 2'b10, 1'b1, 12'h010, 8'h41};
    tbl[2]  = '{2'b11, 12'h010, 8'h41, 12'h020, 8'h42, 2'b01, 1'b1, 12'h020, 8'h42};
    tbl[3]  = '{2'b11, 12'h010, 8'h41, 12'h020, 8'h42, 2'b10, 1'b1, 12'h010, 8'h41};
    tbl[4]  = '{2'b10, 12'h010, 8'h41, 12'h005, 8'h50, 2'b10, 1'b1, 12'h020, 8'h42};
    tbl[5]  = '{2'b10, 12'h010, 8'h41, 12'h006, 8'h51, 2'b10, 1'b1, 12'h005, 8'h50};
    tbl[6]  = '{2'b10, 12'h010, 8'h41, 12'h007, 8'h52, 2'b10, 1'b1, 12'h006, 8'h51};
    tbl[7]  = '{2'b10, 12'h010, 8'h41, 12'h008, 8'h53, 2'b10, 1'b1, 12'h007, 8'h52};
    tbl[8]  = '{2'b00, 12'h010, 8'h41, 12'h008, 8'h53, 2'b00, 1'b1, 12'h008, 8'h53};
    tbl[9]  = '{2'b00, 12'h010, 8'h41, 12'h008, 8'h53, 2'b00, 1'b0, 12'h008, 8'h53};
    tbl[10] = '{2'b10, 12'h010, 8'h41, 12'h0AB, 8'h60, 2'b10, 1'b0, 12'h008, 8'h53};
    tbl[11] = '{2'b11, 12'h3FF, 8'h61, 12'h0AB, 8'h60, 2'b01, 1'b1, 12'h0AB, 8'h60};
    tbl[12] = '{2'b01, 12'h100, 8'h62, 12'h0AB, 8'h60, 2'b01, 1'b1, 12'h3FF, 8'h61};
    tbl[13] = '{2'b00, 12'h100, 8'h62, 12'h0AB, 8'h60, 2'b00, 1'b1, 12'h100, 8'h62};
    tbl[14] = '{2'b00, 12'h100, 8'h62, 12'h0AB, 8'h60, 2'b00, 1'b0, 12'h100, 8'h62};

    rst = 1'b1;
    drive(2'b11, 12'h010, 8'h41, 12'h020, 8'h42, 1'b0);
    for (int r = 0; r < 3; r++) begin
      #1;
      chk_out($sformatf("reset%0d", r), 2'b00, 1'b0, 12'h000, 8'h00, 1'b0);
      tick();
    end
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].valid, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, 1'b0);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_wen,
              tbl[i].exp_addr, tbl[i].exp_data, 1'b0);
      tick();
    end

    run_clear("clear", 1'b0);
    run_clear("clear_mid", 1'b1);

    // Reset lands while the counter is at 9 (write to 8 is on the port).
    drive(2'b01, 12'h123, 8'h77, 12'h000, 8'h00, 1'b1);
    tick();
    bus.clear_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #1;
    chk("rstmid.pre_addr", 32'(bus.display_w_addr), 32'h008);
    chk("rstmid.pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_out("rstmid.hit", 2'b00, 1'b0, 12'h000, 8'h00, 1'b0);
    chk("rstmid.state", 32'(state_dbg), 32'(VWA_IDLE));
    tick();
    rst = 1'b0;
    drive(2'b01, 12'h0AA, 8'h33, 12'h000, 8'h00, 1'b0);
    #1;
    chk_out("rstmid.grant", 2'b01, 1'b0, 12'h000, 8'h00, 1'b0);
    tick();
    drive(2'b00, 12'h000, 8'h00, 12'h000, 8'h00, 1'b0);
    #1;
    chk_out("rstmid.write", 2'b00, 1'b1, 12'h0AA, 8'h33, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
